// File: rtl/vreduction_sequencer.sv
// Two-requester round-robin front end for the vector reduction unit: latches one request,
// clears the unit, streams the operand in LANES-wide beats and returns the result to its owner.
package vector_pkg;
  localparam int NUM_ELEMENTS = 32;
endpackage

module vreduction_sequencer
  import vector_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [2*NUM_ELEMENTS*16-1:0] req_vector,
  input  logic [3:0]                   req_type,
  input  logic [9:0]                   req_imm,
  input  logic [1:0]                   req_bcast,
  output logic [1:0]                   resp_valid,
  input  logic [1:0]                   resp_ready,
  output logic [NUM_ELEMENTS*16-1:0]   resp_vector,
  output logic                         resp_err,
  output logic [NUM_ELEMENTS*16-1:0]   ru_vector_input,
  output logic [LANES*16-1:0]          ru_lane_input,
  output logic [1:0]                   ru_reduction_type,
  output logic [4:0]                   ru_imm,
  output logic                         ru_broadcast,
  output logic                         ru_clear,
  output logic                         ru_input_valid,
  input  logic [NUM_ELEMENTS*16-1:0]   ru_vector_output,
  input  logic                         ru_output_valid,
  output logic                         busy,
  output logic                         err_spurious
);
  localparam int VW     = NUM_ELEMENTS * 16;
  localparam int LW     = LANES * 16;
  localparam int BEATS  = NUM_ELEMENTS / LANES;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_RESP} state_t;

  state_t                   r_state;
  logic                     r_rr_ptr;
  logic                     r_owner;
  logic [BIDX_W-1:0]        r_beat;
  logic [TMR_W-1:0]         r_tmr;
  logic [BEATS-1:0][LW-1:0] r_vec;
  logic [1:0]               r_type;
  logic [4:0]               r_imm;
  logic                     r_bcast;
  logic [VW-1:0]            r_result;
  logic                     r_err;
  logic [1:0]               r_resp_valid;
  logic                     r_clear;
  logic                     r_in_valid;
  logic [LW-1:0]            r_lane;
  logic                     r_spurious;

  logic                     w_any;
  logic                     w_winner;
  logic [BIDX_W-1:0]        w_next_beat;
  logic [1:0]               w_owner_oh;

  assign w_any       = |req_valid;
  assign w_winner    = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_next_beat = r_beat + BIDX_W'(1);
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;

  // Combinational so a request is accepted in the first IDLE cycle it is seen.
  assign req_ready = (!RST && r_state == S_IDLE && w_any) ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: the wide operand and result latches are reset too, so RST mid-operation zeroes every output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 1'b0;
      r_owner      <= 1'b0;
      r_beat       <= '0;
      r_tmr        <= '0;
      r_vec        <= '0;
      r_type       <= '0;
      r_imm        <= '0;
      r_bcast      <= 1'b0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 2'b00;
      r_clear      <= 1'b0;
      r_in_valid   <= 1'b0;
      r_lane       <= '0;
      r_spurious   <= 1'b0;
    end else begin
      if (ru_output_valid && r_state != S_WAIT) r_spurious <= 1'b1;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_vec    <= w_winner ? req_vector[2*VW-1:VW] : req_vector[VW-1:0];
          r_type   <= w_winner ? req_type[3:2] : req_type[1:0];
          r_imm    <= w_winner ? req_imm[9:5] : req_imm[4:0];
          r_bcast  <= req_bcast[w_winner];
          r_owner  <= w_winner;
          r_rr_ptr <= ~w_winner;
          r_clear  <= 1'b1;
          r_state  <= S_CLEAR;
        end
        S_CLEAR: begin
          r_clear    <= 1'b0;
          r_in_valid <= 1'b1;
          r_beat     <= '0;
          r_lane     <= r_vec[BIDX_W'(0)];
          r_state    <= S_FEED;
        end
        S_FEED: if (r_beat == BIDX_W'(BEATS - 1)) begin
          r_in_valid <= 1'b0;
          r_lane     <= '0;
          r_tmr      <= '0;
          r_state    <= S_WAIT;
        end else begin
          r_beat <= w_next_beat;
          r_lane <= r_vec[w_next_beat];
        end
        // A reply arriving on the timeout cycle still wins over the error response.
        S_WAIT: if (ru_output_valid) begin
          r_result     <= ru_vector_output;
          r_err        <= 1'b0;
          r_resp_valid <= w_owner_oh;
          r_state      <= S_RESP;
        end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
          r_result     <= '0;
          r_err        <= 1'b1;
          r_resp_valid <= w_owner_oh;
          r_state      <= S_RESP;
        end else begin
          r_tmr <= r_tmr + TMR_W'(1);
        end
        S_RESP: if (resp_ready[r_owner]) begin
          r_resp_valid <= 2'b00;
          r_err        <= 1'b0;
          r_result     <= '0;
          r_vec        <= '0;
          r_type       <= '0;
          r_imm        <= '0;
          r_bcast      <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid        = r_resp_valid;
  assign resp_vector       = r_result;
  assign resp_err          = r_err;
  assign ru_vector_input   = r_vec;
  assign ru_lane_input     = r_lane;
  assign ru_reduction_type = r_type;
  assign ru_imm            = r_imm;
  assign ru_broadcast      = r_bcast;
  assign ru_clear          = r_clear;
  assign ru_input_valid    = r_in_valid;
  assign busy              = (r_state != S_IDLE);
  assign err_spurious      = r_spurious;

endmodule

// File: tb/tb_vreduction_sequencer.sv
// Scoreboard bench for vreduction_sequencer: the bench plays both requesters and the reduction
// unit, pushing the expected response at grant time and popping it when resp_valid appears.
module tb_vreduction_sequencer;
  import vector_pkg::*;

  localparam int LANES   = 16;
  localparam int TIMEOUT = 64;
  localparam int VW      = NUM_ELEMENTS * 16;
  localparam int LW      = LANES * 16;
  localparam int BEATS   = NUM_ELEMENTS / LANES;

  logic            CLK = 1'b0;
  logic            RST;
  logic [1:0]      req_valid, req_ready, req_bcast, resp_valid, resp_ready;
  logic [2*VW-1:0] req_vector;
  logic [3:0]      req_type;
  logic [9:0]      req_imm;
  logic [VW-1:0]   resp_vector, ru_vector_input, ru_vector_output;
  logic            resp_err, ru_broadcast, ru_clear, ru_input_valid, ru_output_valid;
  logic            busy, err_spurious;
  logic [LW-1:0]   ru_lane_input;
  logic [1:0]      ru_reduction_type;
  logic [4:0]      ru_imm;

  vreduction_sequencer #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_vector(req_vector),
    .req_type(req_type), .req_imm(req_imm), .req_bcast(req_bcast),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_vector(resp_vector),
    .resp_err(resp_err), .ru_vector_input(ru_vector_input), .ru_lane_input(ru_lane_input),
    .ru_reduction_type(ru_reduction_type), .ru_imm(ru_imm), .ru_broadcast(ru_broadcast),
    .ru_clear(ru_clear), .ru_input_valid(ru_input_valid),
    .ru_vector_output(ru_vector_output), .ru_output_valid(ru_output_valid),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            owner;
    logic [VW-1:0] vec;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0, failures = 0, cycle = 0;
  int            rr_model = 0, cur_owner = 0, grant_cycle = 0, resp_cycle = 0;
  logic [1:0]    last_grant;
  logic [VW-1:0] vec_in [2];
  logic [1:0]    type_in [2];
  logic [4:0]    imm_in [2];
  logic          bcast_in [2];
  logic [VW-1:0] cur_vec, got_vec;
  logic [7:0]    cur_op;
  logic [12:0]   out_flags;

  assign out_flags = {|req_ready, |resp_valid, |resp_vector, resp_err, |ru_vector_input,
                      |ru_lane_input, |ru_reduction_type, |ru_imm, ru_broadcast, ru_clear,
                      ru_input_valid, busy, err_spurious};

  // Behaviour of the bench's stand-in reduction unit.
  function automatic logic [VW-1:0] unit_fn(input logic [VW-1:0] v);
    return v ^ {NUM_ELEMENTS{16'hA5C3}};
  endfunction

  task automatic step();
    @(negedge CLK);
    #1;
    cycle++;
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic load_req(input int s);
    for (int i = 0; i < VW / 32; i++) vec_in[s][i*32 +: 32] = $urandom;
    type_in[s]  = 2'($urandom);
    imm_in[s]   = 5'($urandom);
    bcast_in[s] = 1'($urandom);
    req_vector  = {vec_in[1], vec_in[0]};
    req_type    = {type_in[1], type_in[0]};
    req_imm     = {imm_in[1], imm_in[0]};
    req_bcast   = {bcast_in[1], bcast_in[0]};
  endtask

  task automatic do_grant(input int delay);
    int   want;
    bit   got;
    exp_t e;
    got  = 1'b0;
    want = req_valid[rr_model] ? rr_model : 1 - rr_model;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != 2'b00) begin
        got = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_timeout: req_ready=%b after 20 cycles, req_valid=%b", req_ready, req_valid);
      finish_run();
      return;
    end
    last_grant = req_ready;
    checks++;
    if (req_ready !== 2'(1 << want)) begin
      failures++;
      $display("FAIL grant_side: req_ready=%b expected=%b", req_ready, 2'(1 << want));
    end
    cur_owner   = want;
    rr_model    = 1 - want;
    cur_vec     = vec_in[want];
    cur_op      = {type_in[want], imm_in[want], bcast_in[want]};
    grant_cycle = cycle;
    e.owner     = want;
    e.err       = (delay < 0);
    e.vec       = (delay < 0) ? '0 : unit_fn(cur_vec);
    sb.push_back(e);
  endtask

  task automatic do_clear_feed(input logic [1:0] keep, input int spur_beat, input int abort_beat,
                               output bit aborted);
    aborted = 1'b0;
    step();
    checks++;
    if ({ru_clear, ru_input_valid, busy, req_ready} !== 5'b10100) begin
      failures++;
      $display("FAIL clear_ctrl: {clear,in_valid,busy,req_ready}=%b expected=10100",
               {ru_clear, ru_input_valid, busy, req_ready});
    end
    checks++;
    if ({ru_reduction_type, ru_imm, ru_broadcast} !== cur_op) begin
      failures++;
      $display("FAIL op_latch: got=%h expected=%h", {ru_reduction_type, ru_imm, ru_broadcast}, cur_op);
    end
    checks++;
    if (ru_vector_input !== cur_vec) begin
      failures++;
      $display("FAIL vector_latch: got=%h expected=%h", ru_vector_input, cur_vec);
    end
    req_valid = req_valid & keep;
    load_req(cur_owner);
    got_vec = '0;
    for (int b = 0; b < BEATS; b++) begin
      step();
      ru_output_valid = 1'b0;
      if (b == abort_beat) begin
        aborted = 1'b1;
        return;
      end
      checks++;
      if ({ru_clear, ru_input_valid} !== 2'b01) begin
        failures++;
        $display("FAIL feed_ctrl beat %0d: {clear,in_valid}=%b expected=01", b, {ru_clear, ru_input_valid});
      end
      checks++;
      if (ru_lane_input !== cur_vec[b*LW +: LW]) begin
        failures++;
        $display("FAIL lane_beat %0d: got=%h expected=%h", b, ru_lane_input, cur_vec[b*LW +: LW]);
      end
      got_vec[b*LW +: LW] = ru_lane_input;
      if (b == spur_beat) begin
        ru_output_valid  = 1'b1;
        ru_vector_output = ~cur_vec;
      end
    end
  endtask

  task automatic do_wait(input int delay);
    for (int w = 0; w < TIMEOUT; w++) begin
      step();
      ru_output_valid = 1'b0;
      checks++;
      if ({ru_input_valid, resp_valid} !== 3'b000) begin
        failures++;
        $display("FAIL wait_quiet cycle %0d: {in_valid,resp_valid}=%b expected=000", w, {ru_input_valid, resp_valid});
      end
      if (w == delay) begin
        ru_output_valid  = 1'b1;
        ru_vector_output = unit_fn(got_vec);
        break;
      end
    end
    step();
    ru_output_valid  = 1'b0;
    ru_vector_output = '0;
  endtask

  task automatic do_resp(input int hold, input bit poke_other);
    exp_t e;
    resp_cycle = cycle;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: resp_valid=%b with nothing expected", resp_valid);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (resp_valid !== 2'(1 << e.owner)) begin
      failures++;
      $display("FAIL resp_route: resp_valid=%b expected=%b", resp_valid, 2'(1 << e.owner));
    end
    checks++;
    if (resp_vector !== e.vec) begin
      failures++;
      $display("FAIL resp_vector: got=%h expected=%h", resp_vector, e.vec);
    end
    checks++;
    if (resp_err !== e.err) begin
      failures++;
      $display("FAIL resp_err: got=%b expected=%b", resp_err, e.err);
    end
    for (int h = 0; h < hold; h++) begin
      resp_ready = poke_other ? 2'(1 << (1 - e.owner)) : 2'b00;
      step();
      checks++;
      if ({resp_valid, resp_err, req_ready} !== {2'(1 << e.owner), e.err, 2'b00} || resp_vector !== e.vec) begin
        failures++;
        $display("FAIL resp_hold cycle %0d: {resp_valid,err,req_ready}=%b expected=%b vector_ok=%b", h,
                 {resp_valid, resp_err, req_ready}, {2'(1 << e.owner), e.err, 2'b00}, resp_vector === e.vec);
      end
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL resp_no_grant: req_ready=%b expected=00", req_ready);
    end
    resp_ready = 2'(1 << e.owner);
    step();
    resp_ready = 2'b00;
    checks++;
    if ({resp_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL resp_release: {resp_valid,busy}=%b expected=000", {resp_valid, busy});
    end
  endtask

  task automatic run_op(input logic [1:0] keep, input int delay, input int hold, input bit poke_other);
    bit aborted;
    do_grant(delay);
    do_clear_feed(keep, -1, -1, aborted);
    do_wait(delay);
    do_resp(hold, poke_other);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    ru_output_valid = 1'b0;
    sb.delete();
    rr_model = 0;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    ru_output_valid = 1'b0;
    ru_vector_output = '0;
    req_vector = '0;
    req_type = '0;
    req_imm = '0;
    req_bcast = '0;
    step();
    step();
    checks++;
    if (out_flags !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs: nonzero output flags=%b expected all 0", out_flags);
    end
    RST = 1'b0;
    load_req(0);
    load_req(1);
    repeat (3) step();
    checks++;
    if (out_flags !== 13'b0) begin
      failures++;
      $display("FAIL idle_outputs: nonzero output flags=%b expected all 0", out_flags);
    end
  endtask

  task automatic test_single();
    req_valid = 2'b01;
    run_op(2'b00, 2, 0, 1'b0);
  endtask

  task automatic test_latency();
    req_valid = 2'b10;
    run_op(2'b00, 0, 0, 1'b0);
    checks++;
    if (resp_cycle - grant_cycle != BEATS + 3) begin
      failures++;
      $display("FAIL latency: accept->resp_valid=%0d cycles expected=%0d", resp_cycle - grant_cycle, BEATS + 3);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_op(2'b11, k % 3, (k == 1) ? 2 : 0, 1'b1);
      checks++;
      if (last_grant !== 2'(1 << (k % 2))) begin
        failures++;
        $display("FAIL grant_order op %0d: req_ready=%b expected=%b", k, last_grant, 2'(1 << (k % 2)));
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    req_valid = 2'b01;
    run_op(2'b00, -1, 0, 1'b0);
    req_valid = 2'b01;
    run_op(2'b00, TIMEOUT - 1, 0, 1'b0);
  endtask

  task automatic test_stall_spurious();
    bit aborted;
    checks++;
    if (err_spurious !== 1'b0) begin
      failures++;
      $display("FAIL spurious_clean: err_spurious=%b expected=0", err_spurious);
    end
    req_valid = 2'b01;
    do_grant(1);
    do_clear_feed(2'b00, 0, -1, aborted);
    do_wait(1);
    req_valid = 2'b10;
    do_resp(10, 1'b0);
    req_valid = 2'b00;
    checks++;
    if (err_spurious !== 1'b1) begin
      failures++;
      $display("FAIL spurious_flag: err_spurious=%b expected=1", err_spurious);
    end
  endtask

  task automatic test_reset_mid();
    bit aborted;
    req_valid = 2'b01;
    do_grant(0);
    do_clear_feed(2'b11, -1, 1, aborted);
    RST = 1'b1;
    #1;
    checks++;
    if (out_flags !== 13'b0) begin
      failures++;
      $display("FAIL reset_mid_immediate: output flags=%b expected all 0", out_flags);
    end
    step();
    checks++;
    if (out_flags !== 13'b0) begin
      failures++;
      $display("FAIL reset_mid_held: output flags=%b expected all 0", out_flags);
    end
    RST = 1'b0;
    sb.delete();
    rr_model = 0;
    req_valid = 2'b11;
    run_op(2'b00, 1, 0, 1'b0);
    checks++;
    if (last_grant !== 2'b01) begin
      failures++;
      $display("FAIL reset_rr_ptr: first grant after reset=%b expected=01", last_grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_back_to_back();
    test_timeout();
    test_stall_spurious();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d responses never seen, expected 0", sb.size());
    end
    finish_run();
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    finish_run();
  end

endmodule
